voxel_sequencer: RTL and testbench

- Frame-level controller directly upstream of the pixel shader array.
- Streams voxel records from voxel memory and broadcasts each one to every shader for a rasterize pass, then a shade pass (with palette lookup).
- Afterwards sweeps `pixel_index` over the shared pixel bus and pushes each pixel to the framebuffer writer over a valid/ready handshake.

---
 rtl/voxel_sequencer_if.sv | 13 +
 rtl/voxel_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_voxel_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voxel_sequencer_if.sv
// rtl/voxel_sequencer_if.sv - framebuffer write handshake between the sequencer and the framebuffer writer
interface voxel_sequencer_if #(
  parameter int INDEX_BITS = 32,
  parameter int PIXEL_BITS = 8
);
  logic [INDEX_BITS-1:0] fb_addr;
  logic [PIXEL_BITS-1:0] fb_data;
  logic                  fb_valid;
  logic                  fb_ready;

  modport master (output fb_addr, output fb_data, output fb_valid, input fb_ready);
  modport slave  (input fb_addr, input fb_data, input fb_valid, output fb_ready);
endinterface

// File: rtl/voxel_sequencer.sv
// rtl/voxel_sequencer.sv - frame controller: voxel rasterize/shade broadcast then pixel readout to framebuffer
// Optional SKIP_EMPTY_EN: voxels with id 0 are skipped without a pulse or broadcast update.
module voxel_sequencer #(
  parameter int VADDR_BITS     = 12,
  parameter int COORD_BITS     = 8,
  parameter int PALETTE_BITS   = 32 - (COORD_BITS * 3),
  parameter int PIXEL_BITS     = 8,
  parameter int INDEX_BITS     = 32,
  parameter int NUM_PIXELS     = 76800,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [VADDR_BITS:0]                  voxel_count_i,
  output logic                                 busy_o,
  output logic                                 frame_done_o,
  output logic [VADDR_BITS-1:0]                voxel_addr_o,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] voxel_rdata_i,
  output logic [PALETTE_BITS-1:0]              palette_addr_o,
  input  logic [PIXEL_BITS-1:0]                palette_rdata_i,
  output logic                                 shader_clear_o,
  output logic                                 do_rasterize_o,
  output logic                                 do_shade_o,
  output logic [COORD_BITS-1:0]                voxel_x_o,
  output logic [COORD_BITS-1:0]                voxel_y_o,
  output logic [COORD_BITS-1:0]                voxel_z_o,
  output logic [PALETTE_BITS-1:0]              voxel_id_o,
  output logic [PIXEL_BITS-1:0]                palette_entry_o,
  output logic [INDEX_BITS-1:0]                pixel_index_o,
  input  logic                                 rasterizing_done_i,
  input  logic                                 shading_done_i,
  input  logic [PIXEL_BITS-1:0]                pixel_i,
  voxel_sequencer_if.master                    fb,
  output logic [15:0]                          timeout_count_o
);

  localparam int VW = 3*COORD_BITS + PALETTE_BITS;

  typedef enum logic [3:0] {
    IDLE, CLEAR, R_FETCH, R_LATCH, R_WAIT, R_NEXT,
    S_FETCH, S_PAL, S_LATCH, S_WAIT, S_NEXT,
    RD_SETUP, RD_CAPTURE, RD_PUSH
  } state_t;

  state_t                  state_q;
  logic [VADDR_BITS:0]     count_q;
  logic [VADDR_BITS-1:0]   vptr_q;
  logic [INDEX_BITS-1:0]   pix_q;
  logic [7:0]              timer_q;
  logic [15:0]             tmo_q;
  logic [COORD_BITS-1:0]   x_q, y_q, z_q;
  logic [PALETTE_BITS-1:0] id_q;
  logic [PIXEL_BITS-1:0]   pal_q;
  logic                    clear_q, rast_q, shade_q, frame_done_q;
  logic [INDEX_BITS-1:0]   fb_addr_q;
  logic [PIXEL_BITS-1:0]   fb_data_q;
  logic                    fb_valid_q;

  logic [COORD_BITS-1:0]   rd_x, rd_y, rd_z;
  logic [PALETTE_BITS-1:0] rd_id;
  logic                    skip_d;
  logic                    last_voxel_d;
  logic                    timer_expired_d;
  logic [15:0]             tmo_d;

  assign rd_x  = voxel_rdata_i[VW-1 -: COORD_BITS];
  assign rd_y  = voxel_rdata_i[VW-1-COORD_BITS -: COORD_BITS];
  assign rd_z  = voxel_rdata_i[PALETTE_BITS+COORD_BITS-1 -: COORD_BITS];
  assign rd_id = voxel_rdata_i[PALETTE_BITS-1:0];

`ifdef SKIP_EMPTY_EN
  assign skip_d = (rd_id == '0);
`else
  assign skip_d = 1'b0;
`endif

  // count is VADDR_BITS+1 wide so a full memory (2^VADDR_BITS voxels) still terminates
  assign last_voxel_d    = ({1'b0, vptr_q} == (count_q - (VADDR_BITS+1)'(1)));
  assign timer_expired_d = (timer_q == 8'(TIMEOUT_CYCLES - 1));
  assign tmo_d           = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      vptr_q       <= '0;
      pix_q        <= '0;
      timer_q      <= '0;
      tmo_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      id_q         <= '0;
      pal_q        <= '0;
      clear_q      <= 1'b0;
      rast_q       <= 1'b0;
      shade_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_valid_q   <= 1'b0;
    end else begin
      clear_q      <= 1'b0;
      rast_q       <= 1'b0;
      shade_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            count_q <= voxel_count_i;
            vptr_q  <= '0;
            pix_q   <= '0;
            tmo_q   <= '0;
            clear_q <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR:   state_q <= (count_q == '0) ? RD_SETUP : R_FETCH;
        R_FETCH: state_q <= R_LATCH;
        R_LATCH: begin
          if (skip_d) begin
            state_q <= R_NEXT;
          end else begin
            x_q     <= rd_x;
            y_q     <= rd_y;
            z_q     <= rd_z;
            id_q    <= rd_id;
            rast_q  <= 1'b1;
            timer_q <= '0;
            state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rasterizing_done_i) begin
            state_q <= R_NEXT;
          end else if (timer_expired_d) begin
            tmo_q   <= tmo_d;
            state_q <= R_NEXT;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        R_NEXT: begin
          if (last_voxel_d) begin
            vptr_q  <= '0;
            state_q <= S_FETCH;
          end else begin
            vptr_q  <= vptr_q + VADDR_BITS'(1);
            state_q <= R_FETCH;
          end
        end
        S_FETCH: state_q <= S_PAL;
        S_PAL: begin
          if (skip_d) begin
            state_q <= S_NEXT;
          end else begin
            x_q     <= rd_x;
            y_q     <= rd_y;
            z_q     <= rd_z;
            id_q    <= rd_id;
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          pal_q   <= palette_rdata_i;
          shade_q <= 1'b1;
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (shading_done_i) begin
            state_q <= S_NEXT;
          end else if (timer_expired_d) begin
            tmo_q   <= tmo_d;
            state_q <= S_NEXT;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_NEXT: begin
          if (last_voxel_d) begin
            vptr_q  <= '0;
            state_q <= RD_SETUP;
          end else begin
            vptr_q  <= vptr_q + VADDR_BITS'(1);
            state_q <= S_FETCH;
          end
        end
        RD_SETUP: state_q <= RD_CAPTURE;
        RD_CAPTURE: begin
          fb_data_q  <= pixel_i;
          fb_addr_q  <= pix_q;
          fb_valid_q <= 1'b1;
          state_q    <= RD_PUSH;
        end
        RD_PUSH: begin
          if (fb.fb_ready) begin
            fb_valid_q <= 1'b0;
            if (pix_q == INDEX_BITS'(NUM_PIXELS - 1)) begin
              frame_done_q <= 1'b1;
              pix_q        <= '0;
              state_q      <= IDLE;
            end else begin
              pix_q   <= pix_q + INDEX_BITS'(1);
              state_q <= RD_SETUP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // palette memory has one cycle of latency, so its address follows the live voxel word
  assign palette_addr_o  = (state_q == S_PAL && !skip_d) ? rd_id : '0;
  assign busy_o          = (state_q != IDLE);
  assign frame_done_o    = frame_done_q;
  assign voxel_addr_o    = vptr_q;
  assign shader_clear_o  = clear_q;
  assign do_rasterize_o  = rast_q;
  assign do_shade_o      = shade_q;
  assign voxel_x_o       = x_q;
  assign voxel_y_o       = y_q;
  assign voxel_z_o       = z_q;
  assign voxel_id_o      = id_q;
  assign palette_entry_o = pal_q;
  assign pixel_index_o   = pix_q;
  assign timeout_count_o = tmo_q;
  assign fb.fb_addr      = fb_addr_q;
  assign fb.fb_data      = fb_data_q;
  assign fb.fb_valid     = fb_valid_q;

endmodule

// File: tb/tb_voxel_sequencer.sv
// tb/tb_voxel_sequencer.sv - scoreboard bench for voxel_sequencer; SKIP_EMPTY_EN selects skip expectations
module tb_voxel_sequencer;
  localparam int VB = 4;
  localparam int NP = 6;

`ifdef SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk, rst, start;
  logic [VB:0] voxel_count;
  logic        busy, frame_done, shader_clear, do_rasterize, do_shade;
  logic [VB-1:0] voxel_addr;
  logic [31:0] voxel_rdata;
  logic [7:0]  palette_addr, palette_rdata, palette_entry, pixel;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
  logic [31:0] pixel_index;
  logic        rasterizing_done, shading_done;
  logic [15:0] timeout_count;

  voxel_sequencer_if #(.INDEX_BITS(32), .PIXEL_BITS(8)) fbif ();

  voxel_sequencer #(
    .VADDR_BITS(VB), .COORD_BITS(8), .PALETTE_BITS(8), .PIXEL_BITS(8),
    .INDEX_BITS(32), .NUM_PIXELS(NP), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .voxel_count_i(voxel_count),
    .busy_o(busy), .frame_done_o(frame_done), .voxel_addr_o(voxel_addr),
    .voxel_rdata_i(voxel_rdata), .palette_addr_o(palette_addr),
    .palette_rdata_i(palette_rdata), .shader_clear_o(shader_clear),
    .do_rasterize_o(do_rasterize), .do_shade_o(do_shade),
    .voxel_x_o(voxel_x), .voxel_y_o(voxel_y), .voxel_z_o(voxel_z),
    .voxel_id_o(voxel_id), .palette_entry_o(palette_entry),
    .pixel_index_o(pixel_index), .rasterizing_done_i(rasterizing_done),
    .shading_done_i(shading_done), .pixel_i(pixel), .fb(fbif),
    .timeout_count_o(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rast_cnt = 0, shade_cnt = 0, acc_cnt = 0, done_cnt = 0, stall_seen = 0;
  int stall_cnt = 0;
  bit stall_arm = 1'b0;
  bit r_stuck = 1'b0;
  bit prev_rast = 1'b0, prev_shade = 1'b0;

  logic [31:0] vmem [16];
  logic [7:0]  pmem [256];
  logic [31:0] rq [$];
  logic [39:0] sq [$];
  logic [39:0] fq [$];

  function automatic logic [7:0] pix_fn(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (lo * 8'd29) + 8'h11;
  endfunction

  always @(posedge clk) begin
    voxel_rdata   <= vmem[voxel_addr];
    palette_rdata <= pmem[palette_addr];
  end

  assign pixel = pix_fn(pixel_index);

  // shader array model: done 5 cycles after the pulse, low while a pulse is on the bus
  bit r_arm, s_arm;
  int r_left, s_left;
  always @(posedge clk) begin
    if (rst || shader_clear) begin
      r_arm <= 1'b0; r_left <= 0; s_arm <= 1'b0; s_left <= 0;
    end else begin
      if (do_rasterize) begin r_arm <= 1'b1; r_left <= 4; end
      else if (r_left != 0) r_left <= r_left - 1;
      if (do_shade) begin s_arm <= 1'b1; s_left <= 4; end
      else if (s_left != 0) s_left <= s_left - 1;
    end
  end
  assign rasterizing_done = r_arm && (r_left == 0) && !do_rasterize && !r_stuck;
  assign shading_done     = s_arm && (s_left == 0) && !do_shade;

  always @(posedge clk) begin
    #1;
    if (stall_arm && fbif.fb_valid === 1'b1 && fbif.fb_addr == 32'd3 && stall_cnt < 7) begin
      fbif.fb_ready = 1'b0;
      stall_cnt++;
    end else begin
      fbif.fb_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (do_rasterize === 1'b1) begin
        rast_cnt++;
        checks++;
        if (prev_rast) begin errors++; $display("FAIL rast_pulse_width: high two cycles, required one"); end
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL rast_unexpected: got %h, none required", {voxel_x, voxel_y, voxel_z, voxel_id});
        end else if ({voxel_x, voxel_y, voxel_z, voxel_id} !== rq[0]) begin
          errors++; $display("FAIL rast_voxel: got %h required %h", {voxel_x, voxel_y, voxel_z, voxel_id}, rq[0]);
          void'(rq.pop_front());
        end else void'(rq.pop_front());
      end
      if (do_shade === 1'b1) begin
        shade_cnt++;
        checks++;
        if (prev_shade) begin errors++; $display("FAIL shade_pulse_width: high two cycles, required one"); end
        checks++;
        if (sq.size() == 0) begin
          errors++; $display("FAIL shade_unexpected: got %h, none required", {voxel_x, voxel_y, voxel_z, voxel_id, palette_entry});
        end else if ({voxel_x, voxel_y, voxel_z, voxel_id, palette_entry} !== sq[0]) begin
          errors++; $display("FAIL shade_voxel: got %h required %h", {voxel_x, voxel_y, voxel_z, voxel_id, palette_entry}, sq[0]);
          void'(sq.pop_front());
        end else void'(sq.pop_front());
      end
      if (fbif.fb_valid === 1'b1 && fbif.fb_ready === 1'b0) begin
        stall_seen++;
        checks++;
        if (fq.size() == 0 || {fbif.fb_addr, fbif.fb_data} !== fq[0]) begin
          errors++; $display("FAIL fb_stall_hold: got %h required front of queue", {fbif.fb_addr, fbif.fb_data});
        end
      end
      if (fbif.fb_valid === 1'b1 && fbif.fb_ready === 1'b1) begin
        acc_cnt++;
        checks++;
        if (fq.size() == 0) begin
          errors++; $display("FAIL fb_unexpected: got %h, none required", {fbif.fb_addr, fbif.fb_data});
        end else if ({fbif.fb_addr, fbif.fb_data} !== fq[0]) begin
          errors++; $display("FAIL fb_write: got %h required %h", {fbif.fb_addr, fbif.fb_data}, fq[0]);
          void'(fq.pop_front());
        end else void'(fq.pop_front());
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (fq.size() != 0 || busy !== 1'b0) begin
          errors++; $display("FAIL frame_done_state: pending=%0d busy=%b required 0/0", fq.size(), busy);
        end
      end
    end
    prev_rast  = (do_rasterize === 1'b1);
    prev_shade = (do_shade === 1'b1);
  end

  wire [145:0] all_outs = {busy, frame_done, voxel_addr, palette_addr, shader_clear, do_rasterize,
                           do_shade, voxel_x, voxel_y, voxel_z, voxel_id, palette_entry, pixel_index,
                           fbif.fb_addr, fbif.fb_data, fbif.fb_valid, timeout_count};

  task automatic push_frame(input int cnt);
    for (int v = 0; v < cnt; v++) begin
      logic [31:0] w;
      w = vmem[v];
      if (!(SKIP && w[7:0] == 8'd0)) begin
        rq.push_back(w);
        sq.push_back({w, pmem[w[7:0]]});
      end
    end
    for (int p = 0; p < NP; p++) fq.push_back({32'(p), pix_fn(32'(p))});
  endtask

  task automatic run_frame(input int cnt, input bit poke, input int budget);
    int d0;
    d0 = done_cnt;
    push_frame(cnt);
    voxel_count = (VB+1)'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      start = poke && (i == 10);
      voxel_count = (poke && i == 10) ? 5'd5 : (VB+1)'(cnt);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL frame_done_count: got %0d required 1", done_cnt - d0); end
    checks++;
    if (rq.size() != 0 || sq.size() != 0 || fq.size() != 0) begin
      errors++; $display("FAIL leftovers: rast=%0d shade=%0d fb=%0d required 0", rq.size(), sq.size(), fq.size());
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_outs); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || shader_clear !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b clear=%b required 0", busy, shader_clear); end
  endtask

  task automatic test_basic;
    int r0, s0, a0;
    r0 = rast_cnt; s0 = shade_cnt; a0 = acc_cnt;
    run_frame(2, 1'b1, 2000);
    checks++;
    if (rast_cnt - r0 != 2 || shade_cnt - s0 != 2) begin
      errors++; $display("FAIL basic_pulses: rast=%0d shade=%0d required 2/2", rast_cnt - r0, shade_cnt - s0);
    end
    checks++;
    if (acc_cnt - a0 != NP) begin errors++; $display("FAIL basic_writes: got %0d required %0d", acc_cnt - a0, NP); end
  endtask

  task automatic test_empty;
    int k, r0, s0, d0;
    r0 = rast_cnt; s0 = shade_cnt; d0 = done_cnt;
    push_frame(0);
    voxel_count = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 20 && fbif.fb_valid !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 3) begin errors++; $display("FAIL empty_latency: fb_valid after %0d edges required 3", k); end
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (rast_cnt != r0 || shade_cnt != s0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL empty_frame: rast=%0d shade=%0d done=%0d required 0/0/1", rast_cnt - r0, shade_cnt - s0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout;
    int k, d0;
    d0 = done_cnt;
    r_stuck = 1'b1;
    push_frame(1);
    voxel_count = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 20 && do_rasterize !== 1'b1) begin @(negedge clk); k++; end
    k = 0;
    while (k < 400 && do_shade !== 1'b1) begin @(negedge clk); k++; end
    checks++;
    if (k != 259) begin errors++; $display("FAIL timeout_gap: rast->shade %0d cycles required 259", k); end
    checks++;
    if (timeout_count !== 16'd1) begin errors++; $display("FAIL timeout_count: got %0d required 1", timeout_count); end
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    @(negedge clk);
    r_stuck = 1'b0;
    checks++;
    if (done_cnt != d0 + 1 || timeout_count !== 16'd1) begin
      errors++; $display("FAIL timeout_frame: done=%0d tmo=%0d required 1/1", done_cnt - d0, timeout_count);
    end
    run_frame(1, 1'b0, 500);
    checks++;
    if (timeout_count !== 16'd0) begin errors++; $display("FAIL timeout_clear: got %0d required 0", timeout_count); end
  endtask

  task automatic test_stall;
    int s0;
    s0 = stall_seen;
    stall_cnt = 0;
    stall_arm = 1'b1;
    run_frame(1, 1'b0, 500);
    stall_arm = 1'b0;
    checks++;
    if (stall_seen - s0 != 7) begin errors++; $display("FAIL stall_cycles: got %0d required 7", stall_seen - s0); end
  endtask

  task automatic test_reset_mid;
    int k, d0;
    d0 = done_cnt;
    push_frame(2);
    voxel_count = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 100 && do_shade !== 1'b1) begin @(negedge clk); k++; end
    checks++;
    if (k >= 100) begin errors++; $display("FAIL reset_mid_reach: no do_shade within %0d cycles", k); end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h required 0", all_outs); end
    @(negedge clk);
    rst = 1'b0;
    rq.delete(); sq.delete(); fq.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: done=%0d busy=%b required 0/0", done_cnt - d0, busy); end
    run_frame(2, 1'b0, 2000);
  endtask

  task automatic test_full_count;
    int r0, s0;
    r0 = rast_cnt; s0 = shade_cnt;
    run_frame(16, 1'b0, 5000);
    checks++;
    if (rast_cnt - r0 != 16 || shade_cnt - s0 != 16) begin
      errors++; $display("FAIL full_count: rast=%0d shade=%0d required 16/16", rast_cnt - r0, shade_cnt - s0);
    end
  endtask

  task automatic test_skip_empty;
    int r0, s0, want;
    vmem[0] = {8'h21, 8'h32, 8'h43, 8'h00};
    vmem[1] = {8'h54, 8'h65, 8'h76, 8'h05};
    want = SKIP ? 1 : 2;
    r0 = rast_cnt; s0 = shade_cnt;
    run_frame(2, 1'b0, 2000);
    checks++;
    if (rast_cnt - r0 != want || shade_cnt - s0 != want) begin
      errors++; $display("FAIL skip_pulses: rast=%0d shade=%0d required %0d", rast_cnt - r0, shade_cnt - s0, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    voxel_count = '0;
    for (int i = 0; i < 16; i++) vmem[i] = {8'(i*3+1), 8'(i*5+2), 8'(i*7+3), 8'(i+1)};
    for (int i = 0; i < 256; i++) pmem[i] = 8'(i*13+7) ^ 8'hA5;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_empty;
    test_timeout;
    test_stall;
    test_reset_mid;
    test_full_count;
    test_skip_empty;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
